// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl
//   Moore control FSM for a multicycle RV32I datapath with one shared memory.
//   It supports lw, sw, R-type (add/sub/or/slt), addi, beq and jal. Every
//   memory state stalls until mem_ready is high.
// Ports
//   clk, rst (synchronous, active-low)
//   op/f3/f7b5  instruction fields from IR
//   Zero        ALU zero flag
//   mem_ready   memory finishes the current access this cycle
//   mem_req .. ALUControl  per-cycle datapath strobes and mux selects
//   halted      the FSM is in HALT
//   state       current state, for debug
// Parameter
//   ILLEGAL_HALT  1: an unknown opcode halts the FSM; 0: it is treated as a NOP
module rv32i_multicycle_ctrl #(
  parameter logic ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       f7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_exec;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // The immediate format depends only on the opcode, so it is valid in every state.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Only R-type uses sub for f3=000. addi with instr[30] set stays add.
  always_comb begin
    case (f3)
      3'b000:  alu_exec = (op[5] & f7b5) ? 3'b001 : 3'b000;
      3'b110:  alu_exec = 3'b010;
      3'b010:  alu_exec = 3'b011;
      default: alu_exec = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_exec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_exec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset suppresses every side-effecting strobe. The selects still follow the state.
    if (!rst) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb_rv32i_multicycle_ctrl
//   Drives one instruction at a time, using a cycle plan built from the
//   instruction class and random stall counts. It compares every output of
//   two controllers (halting and NOP flavour) against a per-state output table.
module tb_rv32i_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = OP_R;
  logic [2:0] f3 = 3'b000;
  logic       f7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req_h, adr_h, irw_h, pcw_h, mw_h, rw_h, halted_h;
  logic [1:0] res_h, sa_h, sb_h, imm_h;
  logic [2:0] alu_h;
  logic [3:0] st_h;
  logic       mem_req_n, adr_n, irw_n, pcw_n, mw_n, rw_n, halted_n;
  logic [1:0] res_n, sa_n, sb_n, imm_n;
  logic [2:0] alu_n;
  logic [3:0] st_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7b5(f7b5), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req_h), .AdrSrc(adr_h), .IRWrite(irw_h),
    .PCWrite(pcw_h), .MemWrite(mw_h), .RegWrite(rw_h), .ResultSrc(res_h),
    .ALUSrcA(sa_h), .ALUSrcB(sb_h), .ImmSrc(imm_h), .ALUControl(alu_h),
    .halted(halted_h), .state(st_h)
  );

  rv32i_multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut_n (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7b5(f7b5), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req_n), .AdrSrc(adr_n), .IRWrite(irw_n),
    .PCWrite(pcw_n), .MemWrite(mw_n), .RegWrite(rw_n), .ResultSrc(res_n),
    .ALUSrcA(sa_n), .ALUSrcB(sb_n), .ImmSrc(imm_n), .ALUControl(alu_n),
    .halted(halted_n), .state(st_n)
  );

  // {mem_req,AdrSrc,IRWrite,PCWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,halted,state}
  logic [21:0] obs_h, obs_n;
  assign obs_h = {mem_req_h, adr_h, irw_h, pcw_h, mw_h, rw_h, res_h, sa_h, sb_h, imm_h, alu_h, halted_h, st_h};
  assign obs_n = {mem_req_n, adr_n, irw_n, pcw_n, mw_n, rw_n, res_n, sa_n, sb_n, imm_n, alu_n, halted_n, st_n};

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Expected outputs for a state number, written straight from the state table.
  function automatic logic [21:0] exp_out(input int s, input logic [6:0] o, input logic [2:0] fn3,
                                          input logic fb5, input logic z, input logic mr, input logic rn);
    logic       mq = 0, ad = 0, ir = 0, pc = 0, mw = 0, rw = 0, hl = 0;
    logic [1:0] rs = 0, a = 0, b = 0, im;
    logic [2:0] al = 0, ex;
    im = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    ex = (fn3 == 3'b110) ? 3'd2 : (fn3 == 3'b010) ? 3'd3 :
         (fn3 == 3'b000 && o == OP_R && fb5) ? 3'd1 : 3'd0;
    case (s)
      0:  begin mq = 1; b = 2; rs = 2; ir = mr; pc = mr; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin mq = 1; ad = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin mq = 1; ad = 1; mw = 1; end
      6:  begin a = 2; b = 0; al = ex; end
      7:  begin a = 2; b = 1; al = ex; end
      8:  rw = 1;
      9:  begin a = 1; b = 2; pc = 1; end
      10: begin a = 2; b = 0; al = 3'd1; pc = z; end
      11: hl = 1;
      default: ;
    endcase
    if (!rn) begin mq = 0; ir = 0; pc = 0; mw = 0; rw = 0; end
    return {mq, ad, ir, pc, mw, rw, rs, a, b, im, al, hl, 4'(s)};
  endfunction

  // abort_sel: -1 none, -2 random cycle, >=0 that cycle of the plan gets rst=0.
  task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3_i, input logic f7_i,
                           input logic z_i, input int fst, input int mst, input int abort_sel,
                           input int halt_n);
    step_t plan[$];
    int    div = -1;
    int    abort = abort_sel;
    logic  rn;
    for (int i = 0; i < fst; i++) plan.push_back('{0, 1'b0});
    plan.push_back('{0, 1'b1});
    plan.push_back('{1, rnd_bit()});
    case (op_i)
      OP_LW: begin
        plan.push_back('{2, rnd_bit()});
        for (int i = 0; i < mst; i++) plan.push_back('{3, 1'b0});
        plan.push_back('{3, 1'b1});
        plan.push_back('{4, rnd_bit()});
      end
      OP_SW: begin
        plan.push_back('{2, rnd_bit()});
        for (int i = 0; i < mst; i++) plan.push_back('{5, 1'b0});
        plan.push_back('{5, 1'b1});
      end
      OP_R, OP_I: begin
        plan.push_back('{(op_i == OP_R) ? 6 : 7, rnd_bit()});
        plan.push_back('{8, rnd_bit()});
      end
      OP_JAL: begin
        plan.push_back('{9, rnd_bit()});
        plan.push_back('{8, rnd_bit()});
      end
      OP_BEQ: plan.push_back('{10, rnd_bit()});
      default: begin
        div = plan.size();
        for (int i = 0; i < halt_n; i++) plan.push_back('{11, rnd_bit()});
        plan.push_back('{11, rnd_bit()});
        abort = plan.size() - 1;
      end
    endcase
    if (abort == -2) abort = ($urandom_range(5, 0) == 0) ? int'($urandom_range(plan.size() - 1, 0)) : -1;
    op = op_i; f3 = f3_i; f7b5 = f7_i; Zero = z_i;
    for (int i = 0; i < plan.size(); i++) begin
      rn = (i == abort) ? 1'b0 : 1'b1;
      rst = rn;
      mem_ready = plan[i].mr;
      #1;
      check_eq($sformatf("st%0d_op%02h", plan[i].st, op_i), obs_h,
               exp_out(plan[i].st, op_i, f3_i, f7_i, z_i, plan[i].mr, rn));
      if (div < 0 || i < div)
        check_eq("nop_flavour", obs_n, exp_out(plan[i].st, op_i, f3_i, f7_i, z_i, plan[i].mr, rn));
      else if (i == div)
        check_eq("nop_illegal_fetch", obs_n, exp_out(0, op_i, f3_i, f7_i, z_i, plan[i].mr, rn));
      @(posedge clk);
      @(negedge clk);
      if (i == abort) break;
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [2:0] f3s [4];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, OP_BAD};
    f3s = '{3'b000, 3'b110, 3'b010, 3'b101};
    @(negedge clk);
    mem_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_state", obs_h, exp_out(0, op, f3, f7b5, Zero, 1'b1, 1'b0));
    check_eq("reset_state_nop", obs_n, exp_out(0, op, f3, f7b5, Zero, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b1;

    run_instr(OP_R,   3'b000, 1'b0, 1'b0, 0, 0, -1, 0);   // add
    run_instr(OP_LW,  3'b010, 1'b0, 1'b0, 0, 3, -1, 0);   // lw, 3 stalls
    run_instr(OP_SW,  3'b010, 1'b0, 1'b0, 0, 2, -1, 0);   // sw, 2 stalls
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, -1, 0);   // taken
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, -1, 0);   // not taken
    run_instr(OP_I,   3'b000, 1'b1, 1'b0, 0, 0, -1, 0);   // addi keeps add
    run_instr(OP_R,   3'b000, 1'b1, 1'b0, 0, 0, -1, 0);   // sub
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0, -1, 0);
    run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0, -1, 10);  // halt then reset
    run_instr(OP_SW,  3'b010, 1'b0, 1'b0, 0, 2, 3, 0);    // reset inside MEMWRITE
    run_instr(OP_R,   3'b110, 1'b0, 1'b0, 2, 0, -1, 0);   // or, after the abort

    for (int n = 0; n < 300; n++) begin
      int k;
      k = ($urandom_range(15, 0) == 0) ? 6 : int'($urandom_range(5, 0));
      run_instr(ops[k], f3s[$urandom_range(3, 0)], rnd_bit(), rnd_bit(),
                int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), -2,
                int'($urandom_range(4, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
